// File: rtl/boot_verify_seq.sv
// Boot-time sequencer: streams the 32-word verification record into the signature mailbox,
// starts it, and releases the CPU core on a passing verdict. Optional: BOOT_SEQ_IDX_CHECK_EN.
module boot_verify_seq #(
  parameter logic [31:0] REC_BASE  = 32'h0000_0000,
  parameter int unsigned FETCH_TO  = 1024,
  parameter int unsigned VERIFY_TO = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_req,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        mb_wr_en,
  output logic [31:0] mb_wr_data,
  input  logic [31:0] mb_rd_data,
  input  logic        mb_sig_ok,
  output logic        lock_o,
  output logic        cpu_rst_release_o,
  output logic        busy_o,
  output logic        fail_o,
  output logic [2:0]  fail_code_o
);

  localparam logic [2:0] CodeNone        = 3'd0;
  localparam logic [2:0] CodeFetchTo     = 3'd1;
  localparam logic [2:0] CodeVerifyTo    = 3'd2;
  localparam logic [2:0] CodeSigBad      = 3'd3;
  localparam logic [2:0] CodeIdxMismatch = 3'd4;

  localparam logic [31:0] CtrlStart = 32'h0000_0001;

  typedef enum logic [2:0] {
    StIdle, StFetch, StWrite, StStart, StPoll, StPass, StFail, StCheck
  } state_e;

  state_e      state;
  logic [5:0]  wcnt;
  logic [31:0] tcnt;
  logic        fail_req;
  logic [2:0]  fail_code_d;
  logic        unused_status;

  function automatic logic [31:0] word_addr(input logic [5:0] w);
    return REC_BASE + {24'd0, w, 2'b00};
  endfunction

`ifdef BOOT_SEQ_IDX_CHECK_EN
  logic [7:0] exp_idx;

  // Mailbox index after word w: segment-local position plus one, wrapped to segment length.
  function automatic logic [7:0] seg_idx(input logic [5:0] w);
    logic [5:0] k;
    if (w < 6'd8) begin
      return {5'd0, w[2:0] + 3'd1};
    end else if (w < 6'd24) begin
      k = w - 6'd8;
      return {4'd0, k[3:0] + 4'd1};
    end else begin
      k = w - 6'd24;
      return {5'd0, k[2:0] + 3'd1};
    end
  endfunction

  assign unused_status = ^mb_rd_data[29:8];
`else
  assign unused_status = ^mb_rd_data[29:0];
`endif

  always_comb begin
    fail_req    = 1'b0;
    fail_code_d = CodeNone;
    unique case (state)
      StFetch: begin
        if (!rd_valid && tcnt == FETCH_TO - 1) begin
          fail_req    = 1'b1;
          fail_code_d = CodeFetchTo;
        end
      end
      StPoll: begin
        if (mb_rd_data[31]) begin
          if (!(mb_rd_data[30] && mb_sig_ok)) begin
            fail_req    = 1'b1;
            fail_code_d = CodeSigBad;
          end
        end else if (tcnt == VERIFY_TO - 1) begin
          fail_req    = 1'b1;
          fail_code_d = CodeVerifyTo;
        end
      end
`ifdef BOOT_SEQ_IDX_CHECK_EN
      StCheck: begin
        if (mb_rd_data[7:0] != exp_idx) begin
          fail_req    = 1'b1;
          fail_code_d = CodeIdxMismatch;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= StIdle;
      wcnt              <= '0;
      tcnt              <= '0;
      rd_req            <= 1'b0;
      rd_addr           <= '0;
      mb_wr_en          <= 1'b0;
      mb_wr_data        <= '0;
      lock_o            <= 1'b0;
      cpu_rst_release_o <= 1'b0;
      busy_o            <= 1'b0;
      fail_o            <= 1'b0;
      fail_code_o       <= CodeNone;
`ifdef BOOT_SEQ_IDX_CHECK_EN
      exp_idx           <= '0;
`endif
    end else if (fail_req) begin
      // Failing always locks the mailbox so a half-loaded record cannot be restarted.
      state       <= StFail;
      rd_req      <= 1'b0;
      mb_wr_en    <= 1'b0;
      busy_o      <= 1'b0;
      lock_o      <= 1'b1;
      fail_o      <= 1'b1;
      fail_code_o <= fail_code_d;
    end else begin
      unique case (state)
        StIdle: begin
          if (boot_req) begin
            state   <= StFetch;
            wcnt    <= '0;
            tcnt    <= '0;
            rd_req  <= 1'b1;
            rd_addr <= word_addr(6'd0);
            busy_o  <= 1'b1;
          end
        end
        StFetch: begin
          if (rd_valid) begin
            state      <= StWrite;
            rd_req     <= 1'b0;
            mb_wr_en   <= 1'b1;
            mb_wr_data <= rd_data;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        StWrite: begin
          mb_wr_en <= 1'b0;
          wcnt     <= wcnt + 6'd1;
`ifdef BOOT_SEQ_IDX_CHECK_EN
          exp_idx  <= seg_idx(wcnt);
          state    <= StCheck;
`else
          if (wcnt == 6'd31) begin
            state      <= StStart;
            mb_wr_en   <= 1'b1;
            mb_wr_data <= CtrlStart;
          end else begin
            state   <= StFetch;
            tcnt    <= '0;
            rd_req  <= 1'b1;
            rd_addr <= word_addr(wcnt + 6'd1);
          end
`endif
        end
`ifdef BOOT_SEQ_IDX_CHECK_EN
        StCheck: begin
          if (wcnt == 6'd32) begin
            state      <= StStart;
            mb_wr_en   <= 1'b1;
            mb_wr_data <= CtrlStart;
          end else begin
            state   <= StFetch;
            tcnt    <= '0;
            rd_req  <= 1'b1;
            rd_addr <= word_addr(wcnt);
          end
        end
`endif
        StStart: begin
          mb_wr_en <= 1'b0;
          lock_o   <= 1'b1;
          tcnt     <= '0;
          state    <= StPoll;
        end
        StPoll: begin
          if (mb_rd_data[31]) begin
            state  <= StPass;
            busy_o <= 1'b0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        StPass: begin
          cpu_rst_release_o <= 1'b1;
        end
        StFail: begin
          lock_o <= 1'b1;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
